// File: rtl/uart_receiver.sv
// 8N1 UART receiver with a valid/ready output holding register, framing-error and overrun pulses.
// Optional build macro UART_RX_MAJORITY_EN: 2-of-3 majority vote at each bit centre.
module uart_receiver #(
    parameter int unsigned TICKS_PER_BIT = 1250,
    parameter int unsigned HALF_BIT      = TICKS_PER_BIT / 2
) (
    input  logic       clock_12MHz,
    input  logic       reset_n,
    input  logic       uart_rx,
    input  logic       ready,
    output logic [7:0] data,
    output logic       data_valid,
    output logic       framing_error,
    output logic       overrun
);
    localparam logic [10:0] BIT_RELOAD  = 11'(TICKS_PER_BIT - 1);
    localparam logic [10:0] HALF_RELOAD = 11'(HALF_BIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

    state_t      state_q, state_d;
    logic        rx_meta_q, rx_s_q;
    logic [10:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  shift_q, shift_d;
    logic        deliver_q, deliver_d;
    logic [7:0]  data_q, data_d;
    logic        data_valid_q, data_valid_d;
    logic        framing_error_q, framing_error_d;
    logic        overrun_q, overrun_d;
    logic        sample_bit;
    logic        cnt_zero;

    assign cnt_zero = (cnt_q == '0);

`ifdef UART_RX_MAJORITY_EN
    // rx_s captured at counter 2 and 1; combined with the live sample at counter 0
    logic maj2_q, maj2_d, maj1_q, maj1_d;

    always_comb begin
        maj2_d = maj2_q;
        maj1_d = maj1_q;
        if (cnt_q == 11'd2) maj2_d = rx_s_q;
        if (cnt_q == 11'd1) maj1_d = rx_s_q;
    end

    assign sample_bit = (maj2_q & maj1_q) | (maj2_q & rx_s_q) | (maj1_q & rx_s_q);
`else
    assign sample_bit = rx_s_q;
`endif

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        idx_d           = idx_q;
        shift_d         = shift_q;
        deliver_d       = 1'b0;
        framing_error_d = 1'b0;
        overrun_d       = 1'b0;
        data_d          = data_q;
        data_valid_d    = data_valid_q;

        if (ready) data_valid_d = 1'b0;
        // A delivery on the consuming edge replaces the byte; otherwise a full register drops it
        if (deliver_q) begin
            if (data_valid_q && !ready) begin
                overrun_d = 1'b1;
            end else begin
                data_d       = shift_q;
                data_valid_d = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (!rx_s_q) begin
                    state_d = START;
                    cnt_d   = HALF_RELOAD;
                end
            end
            START: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - 11'd1;
                end else if (sample_bit) begin
                    state_d = IDLE;
                end else begin
                    state_d = DATA;
                    idx_d   = 3'd0;
                    cnt_d   = BIT_RELOAD;
                end
            end
            DATA: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - 11'd1;
                end else begin
                    shift_d[idx_q] = sample_bit;
                    cnt_d          = BIT_RELOAD;
                    if (idx_q == 3'd7) state_d = STOP;
                    else               idx_d   = idx_q + 3'd1;
                end
            end
            STOP: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - 11'd1;
                end else begin
                    if (sample_bit) deliver_d       = 1'b1;
                    else            framing_error_d = 1'b1;
                    state_d = WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                if (rx_s_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock_12MHz or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta_q       <= 1'b1;
            rx_s_q          <= 1'b1;
            state_q         <= IDLE;
            cnt_q           <= '0;
            idx_q           <= '0;
            shift_q         <= '0;
            deliver_q       <= 1'b0;
            data_q          <= '0;
            data_valid_q    <= 1'b0;
            framing_error_q <= 1'b0;
            overrun_q       <= 1'b0;
`ifdef UART_RX_MAJORITY_EN
            maj2_q          <= 1'b1;
            maj1_q          <= 1'b1;
`endif
        end else begin
            rx_meta_q       <= uart_rx;
            rx_s_q          <= rx_meta_q;
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            idx_q           <= idx_d;
            shift_q         <= shift_d;
            deliver_q       <= deliver_d;
            data_q          <= data_d;
            data_valid_q    <= data_valid_d;
            framing_error_q <= framing_error_d;
            overrun_q       <= overrun_d;
`ifdef UART_RX_MAJORITY_EN
            maj2_q          <= maj2_d;
            maj1_q          <= maj1_d;
`endif
        end
    end

    assign data          = data_q;
    assign data_valid    = data_valid_q;
    assign framing_error = framing_error_q;
    assign overrun       = overrun_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at a reduced bit period: table of frames plus hand-written
// sequences for false start, overrun, reset mid-frame and the centre-glitch case.
module tb_uart_receiver;
    localparam int T = 40;
    localparam int H = T / 2;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx    = 1'b1;
    logic       rdy   = 1'b1;
    logic [7:0] data;
    logic       dv, fe, ov;

    uart_receiver #(.TICKS_PER_BIT(T), .HALF_BIT(H)) dut (
        .clock_12MHz  (clk),
        .reset_n      (rst_n),
        .uart_rx      (rx),
        .ready        (rdy),
        .data         (data),
        .data_valid   (dv),
        .framing_error(fe),
        .overrun      (ov)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    int   dv_cnt = 0, fe_cnt = 0, ov_cnt = 0, rise_cyc = 0;
    logic dv_prev = 1'b0;
    int   n_chk = 0, n_pass = 0;
    int   fall_cyc;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (dv) dv_cnt <= dv_cnt + 1;
        if (dv && !dv_prev) rise_cyc <= cyc;
        if (fe) fe_cnt <= fe_cnt + 1;
        if (ov) ov_cnt <= ov_cnt + 1;
        dv_prev <= dv;
    end

    typedef struct {
        logic [7:0] b;
        logic       stop;
        logic [7:0] exp_data;
        int         exp_dv;
        int         exp_fe;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic v, input int n);
        @(negedge clk);
        rx = v;
        repeat (n) @(posedge clk);
    endtask

    // glitch >= 0 injects a one-cycle high pulse at the centre of that (zero) data bit
    task automatic send_frame(input logic [7:0] b, input logic stop, input int glitch);
        @(negedge clk);
        rx = 1'b0;
        fall_cyc = cyc;
        repeat (T) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            if (i == glitch) begin
                drive_bit(b[i], H);
                drive_bit(1'b1, 1);
                drive_bit(b[i], T - H - 1);
            end else begin
                drive_bit(b[i], T);
            end
        end
        drive_bit(stop, T);
        drive_bit(1'b1, T);
    endtask

    vec_t vecs[7];
    int   dv0, fe0, ov0, lat;
    logic [7:0] exp_glitch;

    initial begin
        vecs[0] = '{8'hA5, 1'b1, 8'hA5, 1, 0};
        vecs[1] = '{8'h3C, 1'b1, 8'h3C, 1, 0};
        vecs[2] = '{8'h3C, 1'b0, 8'h3C, 0, 1};
        vecs[3] = '{8'h01, 1'b1, 8'h01, 1, 0};
        vecs[4] = '{8'hFF, 1'b1, 8'hFF, 1, 0};
        vecs[5] = '{8'h00, 1'b1, 8'h00, 1, 0};
        vecs[6] = '{8'h80, 1'b1, 8'h80, 1, 0};

        repeat (3) @(posedge clk);
        settle();
        check("reset_data", int'(data), 0);
        check("reset_valid", int'(dv), 0);
        check("reset_ferr", int'(fe), 0);
        check("reset_ovr", int'(ov), 0);
        rst_n = 1'b1;
        repeat (10) @(posedge clk);

        // False start: low well under half a bit
        settle();
        dv0 = dv_cnt; fe0 = fe_cnt;
        drive_bit(1'b0, H / 2);
        drive_bit(1'b1, 2 * T);
        settle();
        check("false_start_valid", dv_cnt - dv0, 0);
        check("false_start_ferr", fe_cnt - fe0, 0);

        for (int v = 0; v < 7; v++) begin
            settle();
            dv0 = dv_cnt; fe0 = fe_cnt; ov0 = ov_cnt;
            send_frame(vecs[v].b, vecs[v].stop, -1);
            settle();
            check($sformatf("vec%0d_data", v), int'(data), int'(vecs[v].exp_data));
            check($sformatf("vec%0d_valid_cycles", v), dv_cnt - dv0, vecs[v].exp_dv);
            check($sformatf("vec%0d_ferr", v), fe_cnt - fe0, vecs[v].exp_fe);
            check($sformatf("vec%0d_ovr", v), ov_cnt - ov0, 0);
            if (vecs[v].exp_dv == 1) begin
                lat = rise_cyc - fall_cyc;
                check($sformatf("vec%0d_latency_in_window(lat=%0d)", v, lat),
                      int'(lat >= 2 + H + 9 * T && lat <= 4 + H + 9 * T), 1);
            end
        end

        // Overrun: consumer stalled across two frames
        settle();
        rdy = 1'b0;
        ov0 = ov_cnt; fe0 = fe_cnt;
        send_frame(8'h11, 1'b1, -1);
        send_frame(8'h22, 1'b1, -1);
        settle();
        check("ovr_data_held", int'(data), 8'h11);
        check("ovr_valid_held", int'(dv), 1);
        check("ovr_pulses", ov_cnt - ov0, 1);
        check("ovr_ferr", fe_cnt - fe0, 0);
        rdy = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rdy = 1'b0;
        #1;
        check("ovr_valid_cleared", int'(dv), 0);
        check("ovr_data_after_accept", int'(data), 8'h11);
        rdy = 1'b1;

        // Reset in the middle of data bit 3 of 0x7E
        drive_bit(1'b0, T);
        drive_bit(1'b0, T);
        drive_bit(1'b1, T);
        drive_bit(1'b1, T);
        drive_bit(1'b1, H);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset_data", int'(data), 0);
        check("midreset_valid", int'(dv), 0);
        check("midreset_ferr", int'(fe), 0);
        check("midreset_ovr", int'(ov), 0);
        rx = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        dv0 = dv_cnt; fe0 = fe_cnt;
        repeat (2 * T) @(posedge clk);
        settle();
        check("midreset_no_delivery", dv_cnt - dv0, 0);
        check("midreset_no_ferr", fe_cnt - fe0, 0);
        dv0 = dv_cnt;
        send_frame(8'h55, 1'b1, -1);
        settle();
        check("after_reset_data", int'(data), 8'h55);
        check("after_reset_valid_cycles", dv_cnt - dv0, 1);

        // One-cycle high glitch at the centre of bit 3 of 0x00
`ifdef UART_RX_MAJORITY_EN
        exp_glitch = 8'h00;
`else
        exp_glitch = 8'h08;
`endif
        dv0 = dv_cnt;
        send_frame(8'h00, 1'b1, 3);
        settle();
        check("glitch_data", int'(data), int'(exp_glitch));
        check("glitch_valid_cycles", dv_cnt - dv0, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- 8N1 UART receive path: samples asynchronous `uart_rx`, recovers bytes LSB-first and presents each on a valid/ready handshake.
- Companion to the transmitter; defaults to 9600 baud from the 12 MHz system clock.
- Flags framing errors (bad stop bit) and overruns (byte completes while the previous byte is unconsumed).

Parameters:
- TICKS_PER_BIT, 1250, clock cycles per bit (12 MHz / 9600). Legal range 16..2047; the tick counter is 11 bits.
- HALF_BIT, TICKS_PER_BIT/2 (625), cycles from start-edge detection to the start-bit midpoint sample.

Ports:
- clock_12MHz  input  1  system clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- uart_rx  input  1  serial line; idle high; asynchronous to the clock.
- data  output  8  received byte; stable while data_valid=1.
- data_valid  output  1  byte available; held until accepted.
- ready  input  1  consumer accepts the byte on a rising edge where data_valid=1 and ready=1.
- framing_error  output  1  one-cycle pulse: stop bit sampled 0.
- overrun  output  1  one-cycle pulse: new byte dropped because the holding register was full.

Behaviour:
- Reset (async assert, sync release) values:
  - data=0, data_valid=0, framing_error=0, overrun=0.
  - State=IDLE, tick counter=0.
  - Both synchronizer flops=1.
- Input conditioning: 2-flop synchronizer on uart_rx; all logic uses the synchronized value rx_s (2-cycle latency).
- States:
  - IDLE: rx_s=0 → START, counter=HALF_BIT-1.
  - START: decrement the counter; at 0 sample rx_s.
    - rx_s=1 → false start, back to IDLE, nothing reported.
    - rx_s=0 → DATA, bit index=0, counter=TICKS_PER_BIT-1.
  - DATA: at counter 0 sample rx_s into shift register bit[index] (LSB first).
    - index<7 → index+1, counter reload.
    - index=7 → STOP, counter reload.
  - STOP: at counter 0 sample rx_s.
    - rx_s=1 → deliver the byte (see handshake).
    - rx_s=0 → framing_error pulses 1 cycle and the byte is discarded.
    - Either way go to WAIT_IDLE.
  - WAIT_IDLE: stay until rx_s=1, then IDLE. A break condition (line held low) never re-triggers.
- Handshake / delivery:
  - Delivery loads `data` and sets data_valid the cycle after the stop sample.
  - data_valid stays high until an edge with ready=1; it drops on that edge unless a new delivery happens on the same edge.
  - Delivery while data_valid=1 and ready=0: the new byte is dropped, data is unchanged, overrun pulses 1 cycle.
  - Delivery while data_valid=1 and ready=1 (same edge): the new byte replaces data, data_valid stays 1, no overrun.
  - ready while data_valid=0 is ignored.
- Latency: data_valid rises 2 + HALF_BIT + 9*TICKS_PER_BIT + 1 cycles (±1) after uart_rx falls. Default is ≈11878 cycles.
- Counter arithmetic: the counter is unsigned 11-bit; no wrap occurs because every reload happens at 0.
- Reset mid-frame aborts immediately. After release, the receiver requires rx_s=1 before it accepts a new start; partial bytes are never delivered.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined: each START/DATA/STOP sample is the 2-of-3 majority of rx_s taken at counter values 2, 1 and 0 of that bit. A single-cycle glitch at the bit centre is rejected.
- Undefined: single sample at counter 0, as described above. Port list and latency are identical either way.

Test Plan:
- Frame 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1) at 1250 cycles/bit, ready=1 → data=0xA5, data_valid high exactly 1 cycle at ≈11878 cycles after the falling edge; framing_error=0, overrun=0.
- uart_rx low for 300 cycles then high → no data_valid, no error, state back in IDLE; a following frame 0x3C is received correctly.
- Frame 0x3C with stop bit driven 0 and then line high → framing_error one pulse, data_valid stays 0, data unchanged; the next frame 0x01 is received.
- ready=0, frames 0x11 then 0x22 → data=0x11 valid held, overrun pulses once at the 0x22 stop sample. Raising ready for 1 cycle clears data_valid.
- reset_n pulsed low mid-data of frame 0x7E → all outputs 0 immediately, no delivery. A subsequent frame 0x55 yields data=0x55.
- With UART_RX_MAJORITY_EN: frame 0x00 with a 1-cycle high glitch at the centre of bit 3 → data=0x00. Without the macro, the same stimulus yields 0x08.
